// File: rtl/myproject_sdiv_16s_7ns_seq.sv
// ---------------------------------------------------------------------------
// myproject_sdiv_16s_7ns_seq
//
// Sequential signed-by-unsigned restoring divider with C semantics.
// A signed dividend (din0) is divided by an unsigned divisor (din1). The
// quotient is truncated toward zero and the remainder takes the sign of the
// dividend. One quotient bit is produced per cycle, MSB first.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst       synchronous active-high reset
//   start        request, sampled only while idle
//   din0         signed dividend, sampled with start
//   din1         unsigned divisor, sampled with start
//   busy         high while a division is in flight
//   done         one-cycle pulse, quot/rem/div_by_zero valid
//   quot         signed quotient (held until the next result)
//   rem          signed remainder (held until the next result)
//   div_by_zero  the held result came from a zero divisor
// ---------------------------------------------------------------------------
module myproject_sdiv_16s_7ns_seq #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 16,
  parameter int rem_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [rem_WIDTH-1:0]  rem,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN
  } state_t;

  state_t                  state_q, state_d;
  // dvd holds the dividend magnitude; quotient bits shift in at the LSB as
  // dividend bits shift out at the MSB, so after the last step it is |q|.
  logic [din0_WIDTH-1:0]   dvd_q, dvd_d;
  logic [din1_WIDTH-1:0]   dsr_q, dsr_d;
  logic [rem_WIDTH-1:0]    prem_q, prem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic                    dz_q, dz_d;
  logic [dout_WIDTH-1:0]   quot_q, quot_d;
  logic [rem_WIDTH-1:0]    rem_q, rem_d;
  logic                    dbz_q, dbz_d;
  logic                    done_q, done_d;

  // |din0| fits in an unsigned magnitude, including 2^15 for the most
  // negative dividend.
  logic [din0_WIDTH-1:0]   din0_mag;
  logic [rem_WIDTH-1:0]    prem_shift;
  logic [rem_WIDTH-1:0]    prem_sub;
  logic                    q_bit;

  assign din0_mag   = din0[din0_WIDTH-1] ? -din0 : din0;
  // The partial remainder is always below the divisor, so the shifted value
  // cannot overflow the extra remainder bit.
  assign prem_shift = {prem_q[rem_WIDTH-2:0], dvd_q[din0_WIDTH-1]};
  assign q_bit      = (prem_shift >= {1'b0, dsr_q});
  assign prem_sub   = prem_shift - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d = din0[din0_WIDTH-1];
          if (din1 == '0) begin
            // Zero divisor skips the iterations entirely.
            dz_d    = 1'b1;
            state_d = S_SIGN;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = din0_mag;
            dsr_d   = din1;
            prem_d  = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        prem_d = q_bit ? prem_sub : prem_shift;
        dvd_d  = {dvd_q[din0_WIDTH-2:0], q_bit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          // Saturate toward the sign of the dividend.
          quot_d = neg_q ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                         : {1'b0, {(dout_WIDTH-1){1'b1}}};
          rem_d  = '0;
          dbz_d  = 1'b1;
        end else begin
          // Negating 2^15 wraps back to -2^15, which is the exact answer.
          quot_d = neg_q ? -dvd_q : dvd_q;
          rem_d  = neg_q ? -prem_q : prem_q;
          dbz_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_myproject_sdiv_16s_7ns_seq.sv
// ---------------------------------------------------------------------------
// tb_myproject_sdiv_16s_7ns_seq
//
// Directed bench for the sequential divider. Expected results come from a
// C-semantics arithmetic model and are queued when a request is issued,
// then popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_myproject_sdiv_16s_7ns_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        start;
  logic [15:0] din0;
  logic [6:0]  din1;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          a;
    int          b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  myproject_sdiv_16s_7ns_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .start       (start),
    .din0        (din0),
    .din1        (din1),
    .busy        (busy),
    .done        (done),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // C-semantics reference: SV int division truncates toward zero and the
  // remainder follows the dividend sign.
  task automatic push_exp(input int a, input int b);
    exp_t e;
    int   q;
    int   r;
    if (b == 0) begin
      q    = (a < 0) ? -32768 : 32767;
      r    = 0;
      e.dz = 1'b1;
    end else begin
      q    = a / b;
      r    = a % b;
      e.dz = 1'b0;
    end
    e.q = 16'(q);
    e.r = 8'(r);
    e.a = a;
    e.b = b;
    sb.push_back(e);
  endtask

  // Presents one request; returns one time unit after E0 with start low.
  task automatic start_op(input int a, input int b, input bit push);
    @(negedge ap_clk);
    start = 1'b1;
    din0  = 16'(a);
    din1  = 7'(b);
    if (push) push_exp(a, b);
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    din0  = 16'($urandom);
    din1  = 7'($urandom);
  endtask

  // Waits (bounded) for done, optionally presenting a second start on
  // cycles inj_at .. inj_at+inj_len-1 relative to E0, then checks latency,
  // busy width and the popped result. Returns one unit after the edge
  // following done.
  task automatic wait_done(input int exp_lat, input int inj_at, input int inj_len,
                           input int ia, input int ib);
    int   n;
    int   bc;
    exp_t e;
    n  = 0;
    bc = 0;
    if (busy) bc++;
    while (!done && n < 100) begin
      if ((n + 1 >= inj_at) && (n + 1 < inj_at + inj_len)) begin
        start = 1'b1;
        din0  = 16'(ia);
        din1  = 7'(ib);
      end else begin
        start = 1'b0;
      end
      @(posedge ap_clk);
      #1;
      n++;
      if (busy) bc++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_cycles", 32'(bc), 32'(exp_lat));
    check("busy_at_done", {31'b0, busy}, 32'd0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      $display("op %0d / %0d : quot=%0d rem=%0d dbz=%0d lat=%0d",
               e.a, e.b, $signed(quot), $signed(rem), div_by_zero, n);
      check("quot", {16'b0, quot}, {16'b0, e.q});
      check("rem", {24'b0, rem}, {24'b0, e.r});
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
    end
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    check("done_pulse_width", {31'b0, done}, 32'd0);
  endtask

  task automatic do_op(input int a, input int b);
    start_op(a, b, 1'b1);
    wait_done((b == 0) ? 1 : 17, 0, 0, 0, 0);
  endtask

  initial begin
    int dones;
    ap_rst = 1'b1;
    start  = 1'b0;
    din0   = '0;
    din1   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quot", {16'b0, quot}, 32'd0);
    check("rst_rem", {24'b0, rem}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    ap_rst = 1'b0;

    // Basic and sign handling.
    do_op(1000, 7);
    do_op(-1000, 7);
    do_op(-7, 7);
    do_op(6, 7);
    do_op(-6, 7);

    // Range extremes.
    do_op(-32768, 1);
    do_op(32767, 127);
    do_op(-32768, 127);
    do_op(0, 5);

    // Divide by zero, then a normal op clears the flag.
    do_op(5, 0);
    do_op(-5, 0);
    do_op(0, 0);
    do_op(1000, 7);

    // Start pulsed mid-operation is ignored.
    start_op(100, 3, 1'b1);
    wait_done(17, 5, 1, 9, 2);
    check("no_queued_op", {31'b0, busy}, 32'd0);

    // Start held through the done cycle is accepted at E18.
    start_op(100, 3, 1'b1);
    push_exp(9, 2);
    wait_done(17, 17, 2, 9, 2);
    wait_done(17, 0, 0, 0, 0);

    // Reset mid-operation aborts without a done pulse.
    start_op(1000, 7, 1'b0);
    repeat (7) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_quot", {16'b0, quot}, 32'd0);
    check("abort_rem", {24'b0, rem}, 32'd0);
    dones = 0;
    repeat (25) begin
      @(posedge ap_clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    do_op(50, 7);

    // A few random requests against the model.
    for (int i = 0; i < 6; i++) begin
      do_op(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 127)));
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/myproject_sdiv_16s_7ns_seq.md
# myproject_sdiv_16s_7ns_seq

Sequential signed-by-unsigned integer divider: the inverse of the mul_Ns_Mns_*_1_1 multiplier cores. It divides a signed dividend (16s) by an unsigned divisor (7ns) and returns a signed quotient (16s) and a signed remainder (8s) with C semantics. It is used in dense and normalisation layers wherever a product must be rescaled by a runtime (non-power-of-two) integer. The iterative radix-2 datapath trades latency for area, against the single-cycle multiplier.

## Interface
- din0_WIDTH, 16, dividend width (signed)
- din1_WIDTH, 7, divisor width (unsigned)
- dout_WIDTH, 16, quotient width; must equal din0_WIDTH
- rem_WIDTH, 8, remainder width; must equal din1_WIDTH+1
- ap_clk  in  1  clock; all state changes on rising edge
- ap_rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- din0  in  din0_WIDTH  signed dividend, sampled with start
- din1  in  din1_WIDTH  unsigned divisor, sampled with start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse: quot/rem/div_by_zero valid
- quot  out  dout_WIDTH  signed quotient, truncated toward zero
- rem  out  rem_WIDTH  signed remainder, sign of dividend
- div_by_zero  out  1  result came from a zero divisor

## Operation
- States: IDLE, CALC, SIGN.
- IDLE, start=1, din1≠0:
  - capture |din0| as a 16-bit unsigned magnitude (32768 representable), the dividend sign, and din1.
  - clear the partial remainder and the iteration counter; go to CALC.
- IDLE, start=1, din1=0: go directly to SIGN with the saturated result below. No CALC cycles.
- CALC: one restoring step per cycle, MSB first.
  - Shift the partial remainder left and bring in the next dividend bit.
  - If the partial remainder ≥ divisor, subtract the divisor and set the quotient bit to 1.
  - The partial remainder is din1_WIDTH+1 bits wide.
  - After din0_WIDTH steps, go to SIGN.
- SIGN:
  - Apply signs: quot = neg ? −q : q; rem = neg ? −r : r.
  - Register quot, rem and div_by_zero; pulse done; go to IDLE.
- Width rules:
  - −32768/1 yields −32768. This is the only case with |q| = 2^15, and it is representable.
  - No other overflow is possible for divisor ≥ 1.
- Divide by zero: quot = 32767 if din0 ≥ 0, else −32768; rem = 0; div_by_zero = 1.
- quot, rem and div_by_zero hold their last values until the next SIGN.
- start outside IDLE is ignored, including during CALC and SIGN. There is no queueing.
- Reset values:
  - state IDLE.
  - busy, done, div_by_zero = 0; quot, rem = 0.
  - All internal registers cleared.
- Reset mid-operation aborts the division. No done pulse is produced for the aborted request.

## Timing
- E0 is the rising edge where start=1 is sampled in IDLE.
- Nonzero divisor:
  - CALC steps occur on E1..E16; SIGN executes on E17.
  - done = 1 from E17 to E18. Latency = din0_WIDTH+1 = 17 cycles.
- Zero divisor: SIGN executes on E1, so done = 1 from E1 to E2.
- busy = 1 from E0 until the SIGN edge, then 0. busy and done are never high together.
- The state is IDLE while done is high. A start presented during the done cycle is accepted at E18.
- Peak throughput: one division per 18 cycles.
- din0 and din1 may change freely after E0.

## Test plan
- 1000/7, start at E0:
  - done only between E17 and E18; quot = 142, rem = 6, div_by_zero = 0.
  - busy high for exactly 17 cycles.
- Sign handling:
  - −1000/7 → quot = −142, rem = −6.
  - −7/7 → −1, 0.
  - 6/7 → 0, 6.
  - −6/7 → 0, −6.
- Range extremes:
  - −32768/1 → −32768, 0.
  - 32767/127 → 258, 1.
  - −32768/127 → −258, −2.
  - 0/5 → 0, 0.
- Divide by zero:
  - 5/0 → done between E1 and E2; quot = 32767, rem = 0, div_by_zero = 1.
  - −5/0 → −32768.
  - The next normal operation clears div_by_zero.
- Handshake:
  - 100/3 started; start pulsed again at E5 with 9/2: ignored, result 33, 1.
  - start held high through the done cycle with 9/2: accepted at E18, done at E35 with 4, 1.
- Reset:
  - ap_rst at E8 of 1000/7 → no done pulse; busy = 0; quot = rem = 0 next cycle.
  - Then 50/7 → 7, 1 with nominal latency.
